// File: rtl/ciscud_mem_respondedor.sv
// ciscud_mem_respondedor: memory responder for the CiscUd bus, fixed wait states.
// Optional error flag for out-of-range addresses: define CISCUD_MEM_ERROR_EN.
module ciscud_mem_respondedor #(
    parameter int ANCHO_DATOS = 8,
    parameter int ANCHO_DIR   = 8,
    parameter int PROFUNDIDAD = 256,
    parameter int ESPERAS     = 2
) (
    input  logic                   Reloj,
    input  logic                   Reiniciar,
    input  logic                   pet,
    input  logic                   esc,
    input  logic [ANCHO_DIR-1:0]   dir,
    input  logic [ANCHO_DATOS-1:0] dato_esc,
    output logic [ANCHO_DATOS-1:0] dato_lec,
    output logic                   listo,
    output logic                   error
);

    localparam int AW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
    localparam logic [3:0] CARGA = 4'(ESPERAS);
    localparam logic [ANCHO_DIR:0] LIMITE = (ANCHO_DIR + 1)'(PROFUNDIDAD);

    typedef enum logic {
        LIBRE,
        ESPERA
    } estado_t;

    estado_t estado_q, estado_d;
    logic [3:0] cnt_q, cnt_d;

    logic                   esc_q, esc_d;
    logic [ANCHO_DIR-1:0]   dir_q, dir_d;
    logic [ANCHO_DATOS-1:0] dato_q, dato_d;

    logic                   listo_q, listo_d;
    logic [ANCHO_DATOS-1:0] lec_q, lec_d;

    logic [ANCHO_DATOS-1:0] mem_q [PROFUNDIDAD];

    logic          completar;
    logic          en_rango;
    logic          escribir;
    logic [AW-1:0] idx;

    // Address decode on the latched copy only; upper bits feed the range test.
    assign en_rango  = {1'b0, dir_q} < LIMITE;
    assign idx       = dir_q[AW-1:0];
    assign completar = (estado_q == ESPERA) && (cnt_q == 4'd0);
    assign escribir  = Reiniciar && completar && esc_q && en_rango;

    // State register: FSM, wait counter, request latch and registered outputs.
    always_ff @(posedge Reloj) begin
        if (!Reiniciar) begin
            estado_q <= LIBRE;
            cnt_q    <= 4'd0;
            esc_q    <= 1'b0;
            dir_q    <= '0;
            dato_q   <= '0;
            listo_q  <= 1'b0;
            lec_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            esc_q    <= esc_d;
            dir_q    <= dir_d;
            dato_q   <= dato_d;
            listo_q  <= listo_d;
            lec_q    <= lec_d;
        end
    end

    // Storage array: not reset, written only on a completing in-range write.
    always_ff @(posedge Reloj) begin
        if (escribir) begin
            mem_q[idx] <= dato_q;
        end
    end

    // Next state: accept in LIBRE, count down in ESPERA, finish at zero.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        esc_d    = esc_q;
        dir_d    = dir_q;
        dato_d   = dato_q;
        unique case (estado_q)
            LIBRE: begin
                if (pet) begin
                    estado_d = ESPERA;
                    cnt_d    = CARGA;
                    esc_d    = esc;
                    dir_d    = dir;
                    dato_d   = dato_esc;
                end
            end
            ESPERA: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    estado_d = LIBRE;
                end
            end
        endcase
    end

    // Output next values: one-cycle listo, read data held until next read.
    always_comb begin
        listo_d = completar;
        lec_d   = lec_q;
        if (completar && !esc_q) begin
            lec_d = en_rango ? mem_q[idx] : '0;
        end
    end

    assign listo    = listo_q;
    assign dato_lec = lec_q;

`ifdef CISCUD_MEM_ERROR_EN
    logic err_q, err_d;

    // Error flag rides alongside listo for out-of-range completions.
    always_ff @(posedge Reloj) begin
        if (!Reiniciar) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Error next value: only on the completing edge of a bad address.
    always_comb begin
        err_d = completar && !en_rango;
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ciscud_mem_respondedor.sv
// Directed bench for ciscud_mem_respondedor: three instances with
// different wait counts and depths share clock, reset and bus inputs.
module tb_ciscud_mem_respondedor;

`ifdef CISCUD_MEM_ERROR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       pet_a, pet_b, pet_c;
    logic       esc;
    logic [7:0] dir;
    logic [7:0] dato_esc;
    logic [7:0] lec_a, lec_b, lec_c;
    logic       listo_a, listo_b, listo_c;
    logic       err_a, err_b, err_c;

    int checks = 0;
    int errors = 0;

    ciscud_mem_respondedor #(
        .ANCHO_DATOS(8), .ANCHO_DIR(8), .PROFUNDIDAD(200), .ESPERAS(2)
    ) u_a (
        .Reloj(clk), .Reiniciar(rst_n), .pet(pet_a), .esc(esc),
        .dir(dir), .dato_esc(dato_esc), .dato_lec(lec_a),
        .listo(listo_a), .error(err_a)
    );

    ciscud_mem_respondedor #(
        .ANCHO_DATOS(8), .ANCHO_DIR(8), .PROFUNDIDAD(256), .ESPERAS(0)
    ) u_b (
        .Reloj(clk), .Reiniciar(rst_n), .pet(pet_b), .esc(esc),
        .dir(dir), .dato_esc(dato_esc), .dato_lec(lec_b),
        .listo(listo_b), .error(err_b)
    );

    ciscud_mem_respondedor #(
        .ANCHO_DATOS(8), .ANCHO_DIR(8), .PROFUNDIDAD(256), .ESPERAS(15)
    ) u_c (
        .Reloj(clk), .Reiniciar(rst_n), .pet(pet_c), .esc(esc),
        .dir(dir), .dato_esc(dato_esc), .dato_lec(lec_c),
        .listo(listo_c), .error(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_pet(input int inst, input logic v);
        case (inst)
            0:       pet_a = v;
            1:       pet_b = v;
            default: pet_c = v;
        endcase
    endtask

    function automatic logic cur_listo(input int inst);
        case (inst)
            0:       return listo_a;
            1:       return listo_b;
            default: return listo_c;
        endcase
    endfunction

    function automatic logic [7:0] cur_lec(input int inst);
        case (inst)
            0:       return lec_a;
            1:       return lec_b;
            default: return lec_c;
        endcase
    endfunction

    function automatic logic cur_err(input int inst);
        case (inst)
            0:       return err_a;
            1:       return err_b;
            default: return err_c;
        endcase
    endfunction

    // One request; lat = edges from acceptance to listo (0 on timeout).
    task automatic req(input int inst, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input bit mut, input bit tog,
                       output int lat, output logic [7:0] rd,
                       output logic er);
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        esc = w;
        dir = a;
        dato_esc = d;
        set_pet(inst, 1'b1);
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (cur_listo(inst)) begin
                lat = n;
                rd  = cur_lec(inst);
                er  = cur_err(inst);
                set_pet(inst, 1'b0);
                break;
            end
            if (mut && n == 1) begin
                dir = a + 8'd1;
                dato_esc = 8'hFF;
            end
            if (tog) set_pet(inst, n[0]);
        end
        if (lat == 0) set_pet(inst, 1'b0);
    endtask

    task automatic test_reset();
        int lat;
        int hits;
        logic [7:0] rd;
        logic er;
        @(negedge clk);
        pet_a = 1'b1;
        esc = 1'b1;
        dir = 8'h10;
        dato_esc = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (listo_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_listo got %b want 0", listo_a);
        end
        checks++;
        if (lec_a !== 8'h00) begin
            errors++;
            $display("FAIL rst_lec got %h want 00", lec_a);
        end
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_err got %b want 0", err_a);
        end
        pet_a = 1'b0;
        rst_n = 1'b1;
        req(0, 1'b1, 8'h10, 8'h5A, 0, 0, lat, rd, er);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL pre_wr_lat got %0d want 3", lat);
        end
        req(0, 1'b0, 8'h10, 8'h00, 0, 0, lat, rd, er);
        @(negedge clk);
        pet_a = 1'b1;
        esc = 1'b1;
        dir = 8'h10;
        dato_esc = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        pet_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (lec_a !== 8'h00) begin
            errors++;
            $display("FAIL abort_lec got %h want 00", lec_a);
        end
        rst_n = 1'b1;
        hits = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (listo_a) hits++;
        end
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL abort_listo got %0d pulses want 0", hits);
        end
        req(0, 1'b0, 8'h10, 8'h00, 0, 0, lat, rd, er);
        checks++;
        if (rd !== 8'h5A) begin
            errors++;
            $display("FAIL abort_mem got %h want 5a", rd);
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic [7:0] rd;
        logic er;
        req(0, 1'b1, 8'h05, 8'h3C, 0, 0, lat, rd, er);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL wr_lat got %0d want 3", lat);
        end
        checks++;
        if (rd !== 8'h5A) begin
            errors++;
            $display("FAIL wr_lec_hold got %h want 5a", rd);
        end
        req(0, 1'b0, 8'h05, 8'h00, 0, 0, lat, rd, er);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL rd_lat got %0d want 3", lat);
        end
        checks++;
        if (rd !== 8'h3C) begin
            errors++;
            $display("FAIL rd_data got %h want 3c", rd);
        end
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL rd_err got %b want 0", er);
        end
        @(negedge clk);
        checks++;
        if (listo_a !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse got %b want 0", listo_a);
        end
    endtask

    task automatic test_zero_wait();
        int lat;
        logic [7:0] rd;
        logic er;
        logic exp;
        req(1, 1'b1, 8'h07, 8'h42, 0, 0, lat, rd, er);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL z_wr_lat got %0d want 1", lat);
        end
        req(1, 1'b0, 8'h07, 8'h00, 0, 0, lat, rd, er);
        checks++;
        if (lat !== 1 || rd !== 8'h42) begin
            errors++;
            $display("FAIL z_rd got lat %0d data %h want 1 42", lat, rd);
        end
        @(negedge clk);
        esc = 1'b0;
        dir = 8'h07;
        pet_b = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp = (i % 2 == 1) && (i < 9);
            checks++;
            if (listo_b !== exp) begin
                errors++;
                $display("FAIL z_b2b_%0d got %b want %b", i, listo_b, exp);
            end
            if (exp) begin
                checks++;
                if (lec_b !== 8'h42) begin
                    errors++;
                    $display("FAIL z_b2b_data got %h want 42", lec_b);
                end
            end
            if (i == 7) pet_b = 1'b0;
        end
    endtask

    task automatic test_input_stability();
        int lat;
        logic [7:0] rd;
        logic er;
        req(0, 1'b1, 8'h21, 8'h99, 0, 0, lat, rd, er);
        req(0, 1'b1, 8'h20, 8'h11, 1, 0, lat, rd, er);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL stab_lat got %0d want 3", lat);
        end
        req(0, 1'b0, 8'h20, 8'h00, 0, 0, lat, rd, er);
        checks++;
        if (rd !== 8'h11) begin
            errors++;
            $display("FAIL stab_20 got %h want 11", rd);
        end
        req(0, 1'b0, 8'h21, 8'h00, 0, 0, lat, rd, er);
        checks++;
        if (rd !== 8'h99) begin
            errors++;
            $display("FAIL stab_21 got %h want 99", rd);
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [7:0] rd;
        logic er;
        req(0, 1'b1, 8'hC7, 8'h33, 0, 0, lat, rd, er);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL oor_edge_err got %b want 0", er);
        end
        req(0, 1'b0, 8'hC7, 8'h00, 0, 0, lat, rd, er);
        checks++;
        if (rd !== 8'h33) begin
            errors++;
            $display("FAIL oor_edge_rd got %h want 33", rd);
        end
        req(0, 1'b0, 8'hF0, 8'h00, 0, 0, lat, rd, er);
        checks++;
        if (lat !== 3 || rd !== 8'h00) begin
            errors++;
            $display("FAIL oor_rd got lat %0d data %h want 3 00", lat, rd);
        end
        checks++;
        if (er !== ERR_EN) begin
            errors++;
            $display("FAIL oor_rd_err got %b want %b", er, ERR_EN);
        end
        @(negedge clk);
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_clear got %b want 0", err_a);
        end
        req(0, 1'b1, 8'hF0, 8'h77, 0, 0, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== ERR_EN) begin
            errors++;
            $display("FAIL oor_wr got lat %0d err %b want 3 %b", lat, er, ERR_EN);
        end
        req(0, 1'b0, 8'hC7, 8'h00, 0, 0, lat, rd, er);
        checks++;
        if (rd !== 8'h33) begin
            errors++;
            $display("FAIL oor_wr_discard got %h want 33", rd);
        end
    endtask

    task automatic test_max_wait();
        int lat;
        logic [7:0] rd;
        logic er;
        req(2, 1'b1, 8'h03, 8'h5C, 0, 1, lat, rd, er);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL max_wr_lat got %0d want 16", lat);
        end
        req(2, 1'b0, 8'h03, 8'h00, 0, 1, lat, rd, er);
        checks++;
        if (lat !== 16 || rd !== 8'h5C) begin
            errors++;
            $display("FAIL max_rd got lat %0d data %h want 16 5c", lat, rd);
        end
        @(negedge clk);
        checks++;
        if (listo_c !== 1'b0) begin
            errors++;
            $display("FAIL max_pulse got %b want 0", listo_c);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pet_a = 1'b0;
        pet_b = 1'b0;
        pet_c = 1'b0;
        esc = 1'b0;
        dir = 8'h00;
        dato_esc = 8'h00;
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_zero_wait();
        test_input_stability();
        test_out_of_range();
        test_max_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
